// File: rtl/writeback_queue.sv
// Writeback queue: gathers up to 3 completed results/cycle, drains up to 2/cycle to the regfile write ports.
// Latency: an entry is visible on update outputs the cycle after the edge that enqueued it (no bypass).
// Backpressure: stall holds head/outputs; in_ready drops above DEPTH-3; excess enqueues drop and set sticky overflow.
// Optional build macro WBQ_OVF_COUNT_EN adds an 8-bit saturating dropped-entry counter (ovf_count).
module writeback_queue #(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic [2:0]       in_valid,
  input  logic [5:0]       in_reg0,
  input  logic [5:0]       in_reg1,
  input  logic [5:0]       in_reg2,
  input  logic [31:0]      in_value0,
  input  logic [31:0]      in_value1,
  input  logic [31:0]      in_value2,
  output logic             in_ready,
  output logic [5:0]       reg_to_update1,
  output logic [31:0]      new_value1,
  output logic             update1,
  output logic [5:0]       reg_to_update2,
  output logic [31:0]      new_value2,
  output logic             update2,
  output logic [PTR_W:0]   count,
  output logic             overflow
`ifdef WBQ_OVF_COUNT_EN
  ,
  output logic [7:0]       ovf_count
`endif
);

  localparam int             RDY_MAX_I = DEPTH - 3;
  localparam logic [PTR_W:0] DEPTH_C   = DEPTH[PTR_W:0];
  localparam logic [PTR_W:0] RDY_MAX   = RDY_MAX_I[PTR_W:0];
  localparam logic [PTR_W:0] ONE_C     = {{PTR_W{1'b0}}, 1'b1};
  localparam logic [PTR_W-1:0] ONE_P   = {{(PTR_W-1){1'b0}}, 1'b1};

  // Registered state
  logic [5:0]       mem_reg_q [DEPTH];
  logic [5:0]       mem_reg_d [DEPTH];
  logic [31:0]      mem_val_q [DEPTH];
  logic [31:0]      mem_val_d [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             overflow_q, overflow_d;
`ifdef WBQ_OVF_COUNT_EN
  logic [7:0]       ovf_cnt_q, ovf_cnt_d;
  logic [8:0]       ovf_sum;
`endif

  // Per-cycle working signals
  logic [5:0]       in_reg_a [3];
  logic [31:0]      in_val_a [3];
  logic [PTR_W-1:0] head1;
  logic             upd1, upd2;
  logic [1:0]       pop_n;
  logic [PTR_W:0]   pop_ext;
  logic [PTR_W:0]   free_n;
  logic [PTR_W:0]   acc_n;
  logic [1:0]       drop_n;
  logic [PTR_W-1:0] wr_idx;

  assign in_reg_a[0] = in_reg0;
  assign in_reg_a[1] = in_reg1;
  assign in_reg_a[2] = in_reg2;
  assign in_val_a[0] = in_value0;
  assign in_val_a[1] = in_value1;
  assign in_val_a[2] = in_value2;

  // Drain side: present the two oldest entries; hold back the younger one on a same-register collision
  always_comb begin
    head1          = head_q + ONE_P;
    upd1           = (count_q != '0);
    upd2           = (count_q > ONE_C) && (mem_reg_q[head1] != mem_reg_q[head_q]);
    update1        = upd1;
    update2        = upd2;
    reg_to_update1 = upd1 ? mem_reg_q[head_q] : 6'd0;
    new_value1     = upd1 ? mem_val_q[head_q] : 32'd0;
    reg_to_update2 = upd2 ? mem_reg_q[head1]  : 6'd0;
    new_value2     = upd2 ? mem_val_q[head1]  : 32'd0;
    pop_n          = stall ? 2'd0 : ({1'b0, upd1} + {1'b0, upd2});
    pop_ext        = {{(PTR_W-1){1'b0}}, pop_n};
    in_ready       = (count_q <= RDY_MAX);
    count          = count_q;
    overflow       = overflow_q;
  end

  // Fill side: compact non-zero-register producers in port order into free slots (including slots popped this cycle)
  always_comb begin
    mem_reg_d = mem_reg_q;
    mem_val_d = mem_val_q;
    acc_n     = '0;
    drop_n    = 2'd0;
    wr_idx    = tail_q;
    free_n    = DEPTH_C - count_q + pop_ext;
    for (int i = 0; i < 3; i++) begin
      if (in_valid[i] && (in_reg_a[i] != 6'd0)) begin
        if (acc_n < free_n) begin
          wr_idx            = tail_q + acc_n[PTR_W-1:0];
          mem_reg_d[wr_idx] = in_reg_a[i];
          mem_val_d[wr_idx] = in_val_a[i];
          acc_n             = acc_n + ONE_C;
        end else begin
          drop_n = drop_n + 2'd1;
        end
      end
    end
    head_d     = head_q + pop_ext[PTR_W-1:0];
    tail_d     = tail_q + acc_n[PTR_W-1:0];
    count_d    = count_q + acc_n - pop_ext;
    overflow_d = overflow_q | (drop_n != 2'd0);
  end

`ifdef WBQ_OVF_COUNT_EN
  // Saturating tally of dropped entries
  always_comb begin
    ovf_sum   = {1'b0, ovf_cnt_q} + {7'd0, drop_n};
    ovf_cnt_d = ovf_sum[8] ? 8'hFF : ovf_sum[7:0];
    ovf_count = ovf_cnt_q;
  end
`endif

  // State register with synchronous active-low clear
  always_ff @(posedge clk) begin
    if (!reset) begin
      mem_reg_q  <= '{default: '0};
      mem_val_q  <= '{default: '0};
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
`ifdef WBQ_OVF_COUNT_EN
      ovf_cnt_q  <= 8'd0;
`endif
    end else begin
      mem_reg_q  <= mem_reg_d;
      mem_val_q  <= mem_val_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
`ifdef WBQ_OVF_COUNT_EN
      ovf_cnt_q  <= ovf_cnt_d;
`endif
    end
  end

endmodule
